// File: rtl/seg7_scan_decoder.sv
// Recovers digit values from a multiplexed, active-low 7-segment display bus.
// Each digit must hold steady for STABLE_CYCLES cycles before it is accepted. A full set of digits forms one frame.
module seg7_scan_decoder #(
   parameter int DIGITS        = 4,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [6:0]            seg,
   input  logic [DIGITS-1:0]     an,
   output logic [4*DIGITS-1:0]   bcd,
   output logic [DIGITS-1:0]     blank_mask,
   output logic [DIGITS-1:0]     err_mask,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  overrun
);

   typedef enum logic {SCAN, LOAD} state_t;

   localparam logic [7:0]        STABLE = 8'(STABLE_CYCLES);
   localparam logic [DIGITS-1:0] ONE    = DIGITS'(1);

   state_t              state, state_next;
   logic [6:0]          prev_seg;
   logic [DIGITS-1:0]   prev_an;
   logic [7:0]          stab_cnt, stab_cnt_next;
   logic [DIGITS-1:0]   an_low, accept_bits, captured, captured_next;
   logic                qualified, accept;
   logic [3:0]          nibble;
   logic                is_blank, is_err;
   logic [4*DIGITS-1:0] stage_bcd;
   logic [DIGITS-1:0]   stage_blank, stage_err;
   logic                frame_load, frame_drop;

   // Ghosted or idle select lines (zero or several digits low) never count as a sample.
   assign an_low    = ~an;
   assign qualified = (an_low != '0) && ((an_low & (an_low - ONE)) == '0);

   always_comb begin
      stab_cnt_next = 8'd0;
      if (qualified && (seg == prev_seg) && (an == prev_an))
         stab_cnt_next = (stab_cnt == STABLE) ? stab_cnt : stab_cnt + 8'd1;
      else if (qualified)
         stab_cnt_next = 8'd1;
   end

   // Accept only on the transition into STABLE, so that a long dwell is captured once.
   assign accept      = (stab_cnt_next == STABLE) && (stab_cnt != STABLE);
   assign accept_bits = accept ? an_low : '0;

   always_comb begin
      nibble   = 4'hE;
      is_blank = 1'b0;
      is_err   = 1'b0;
      case (seg)
         7'b0000001: nibble = 4'h0;
         7'b1001111: nibble = 4'h1;
         7'b0010010: nibble = 4'h2;
         7'b0000110: nibble = 4'h3;
         7'b1001100: nibble = 4'h4;
         7'b0100100: nibble = 4'h5;
         7'b0100000: nibble = 4'h6;
         7'b0001111: nibble = 4'h7;
         7'b0000000: nibble = 4'h8;
         7'b0000100: nibble = 4'h9;
         7'b1111111: begin nibble = 4'hF; is_blank = 1'b1; end
         default:    is_err = 1'b1;
      endcase
   end

   // LOAD reads the staging values that were written up to the previous edge.
   // New digits may still be accepted during LOAD, and they start the next frame.
   always_comb begin
      state_next    = state;
      captured_next = captured | accept_bits;
      frame_load    = 1'b0;
      frame_drop    = 1'b0;
      case (state)
         SCAN: if (captured_next == '1) state_next = LOAD;
         LOAD: begin
            state_next    = SCAN;
            captured_next = accept_bits;
            if (!out_valid || out_ready) frame_load = 1'b1;
            else                         frame_drop = 1'b1;
         end
         default: state_next = SCAN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= SCAN;
         prev_seg    <= '0;
         prev_an     <= '0;
         stab_cnt    <= '0;
         captured    <= '0;
         stage_bcd   <= '0;
         stage_blank <= '0;
         stage_err   <= '0;
      end else begin
         state    <= state_next;
         prev_seg <= seg;
         prev_an  <= an;
         stab_cnt <= stab_cnt_next;
         captured <= captured_next;
         for (int i = 0; i < DIGITS; i++) begin
            if (accept_bits[i]) begin
               stage_bcd[4*i +: 4] <= nibble;
               stage_blank[i]      <= is_blank;
               stage_err[i]        <= is_err;
            end
         end
      end
   end

   // A dropped frame leaves the presented frame untouched and raises a one-cycle overrun pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         bcd        <= '0;
         blank_mask <= '0;
         err_mask   <= '0;
         out_valid  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         overrun <= frame_drop;
         if (frame_load) begin
            bcd        <= stage_bcd;
            blank_mask <= stage_blank;
            err_mask   <= stage_err;
            out_valid  <= 1'b1;
         end else if (out_ready) begin
            out_valid  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed testbench for seg7_scan_decoder: nominal frames, short dwell, blank/illegal digits,
// backpressure, ghosting and mid-frame reset, each with hand-computed expectations.
module tb_seg7_scan_decoder;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic [15:0] bcd;
   logic [3:0]  blank_mask, err_mask;
   logic        out_valid, out_ready, overrun;

   int assertions = 0;
   int failures   = 0;

   always #5 clk = ~clk;

   seg7_scan_decoder #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .seg(seg), .an(an), .bcd(bcd),
      .blank_mask(blank_mask), .err_mask(err_mask),
      .out_valid(out_valid), .out_ready(out_ready), .overrun(overrun)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertions++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [3:0] sel(input int idx);
      logic [3:0] one_hot;
      one_hot = 4'b0001 << idx;
      return ~one_hot;
   endfunction

   // Drive inputs at a falling edge, then wait the requested number of cycles.
   task automatic applyStimulus(input logic [3:0] an_val, input logic [6:0] seg_val, input int cycles);
      an  = an_val;
      seg = seg_val;
      repeat (cycles) @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; an = 4'hF; seg = 7'h7F; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      checkOutput("reset_bcd", 32'(bcd), 32'h0);
      checkOutput("reset_valid", 32'(out_valid), 32'h0);
      checkOutput("reset_blank", 32'(blank_mask), 32'h0);
      checkOutput("reset_err", 32'(err_mask), 32'h0);
      checkOutput("reset_overrun", 32'(overrun), 32'h0);

      // Nominal frame 1,2,3,4 while the consumer is not ready.
      applyStimulus(sel(0), 7'h4F, 8);
      applyStimulus(sel(1), 7'h12, 8);
      applyStimulus(sel(2), 7'h06, 8);
      applyStimulus(sel(3), 7'h4C, 4);
      checkOutput("nominal_valid_early", 32'(out_valid), 32'h0);
      applyStimulus(sel(3), 7'h4C, 1);
      checkOutput("nominal_valid", 32'(out_valid), 32'h1);
      checkOutput("nominal_bcd", 32'(bcd), 32'h4321);
      checkOutput("nominal_blank", 32'(blank_mask), 32'h0);
      checkOutput("nominal_err", 32'(err_mask), 32'h0);
      applyStimulus(sel(3), 7'h4C, 3);

      // Second frame 5,6,7,8 completes under backpressure and is dropped.
      applyStimulus(sel(0), 7'h24, 8);
      applyStimulus(sel(1), 7'h20, 8);
      applyStimulus(sel(2), 7'h0F, 8);
      applyStimulus(sel(3), 7'h00, 4);
      checkOutput("bp_overrun_early", 32'(overrun), 32'h0);
      applyStimulus(sel(3), 7'h00, 1);
      checkOutput("bp_overrun", 32'(overrun), 32'h1);
      checkOutput("bp_bcd_held", 32'(bcd), 32'h4321);
      checkOutput("bp_valid_held", 32'(out_valid), 32'h1);
      applyStimulus(sel(3), 7'h00, 1);
      checkOutput("bp_overrun_pulse", 32'(overrun), 32'h0);
      checkOutput("bp_bcd_still", 32'(bcd), 32'h4321);
      out_ready = 1'b1;
      applyStimulus(sel(3), 7'h00, 1);
      checkOutput("bp_valid_cleared", 32'(out_valid), 32'h0);
      applyStimulus(sel(3), 7'h00, 1);

      // Short dwell on digit 2 must not complete the frame.
      applyStimulus(sel(0), 7'h04, 8);
      applyStimulus(sel(1), 7'h01, 8);
      applyStimulus(sel(2), 7'h24, 3);
      applyStimulus(sel(3), 7'h0F, 8);
      checkOutput("short_dwell_no_frame", 32'(out_valid), 32'h0);
      applyStimulus(sel(2), 7'h24, 4);
      checkOutput("short_dwell_early", 32'(out_valid), 32'h0);
      applyStimulus(sel(2), 7'h24, 1);
      checkOutput("short_dwell_valid", 32'(out_valid), 32'h1);
      checkOutput("short_dwell_bcd", 32'(bcd), 32'h7509);
      applyStimulus(sel(2), 7'h24, 1);
      checkOutput("ready_clears_valid", 32'(out_valid), 32'h0);

      // Blank on digit 0 and an illegal pattern on digit 1.
      applyStimulus(sel(0), 7'h7F, 8);
      applyStimulus(sel(1), 7'h7E, 8);
      applyStimulus(sel(2), 7'h12, 8);
      applyStimulus(sel(3), 7'h06, 5);
      checkOutput("blank_err_valid", 32'(out_valid), 32'h1);
      checkOutput("blank_err_bcd", 32'(bcd), 32'h32EF);
      checkOutput("blank_mask", 32'(blank_mask), 32'h1);
      checkOutput("err_mask", 32'(err_mask), 32'h2);
      applyStimulus(sel(3), 7'h06, 3);

      // Ghosted select is ignored, so digits 1..3 alone never complete a frame.
      applyStimulus(4'b1100, 7'h4F, 10);
      applyStimulus(sel(1), 7'h12, 8);
      applyStimulus(sel(2), 7'h06, 8);
      applyStimulus(sel(3), 7'h4C, 8);
      checkOutput("ghost_no_frame", 32'(out_valid), 32'h0);

      // Reset with three digits captured, then the next frame needs all four.
      rst = 1'b1;
      applyStimulus(sel(3), 7'h4C, 2);
      rst = 1'b0;
      checkOutput("midreset_bcd", 32'(bcd), 32'h0);
      checkOutput("midreset_blank", 32'(blank_mask), 32'h0);
      checkOutput("midreset_err", 32'(err_mask), 32'h0);
      checkOutput("midreset_valid", 32'(out_valid), 32'h0);
      applyStimulus(sel(0), 7'h4C, 8);
      checkOutput("post_reset_partial", 32'(out_valid), 32'h0);
      applyStimulus(sel(1), 7'h24, 8);
      applyStimulus(sel(2), 7'h20, 8);
      applyStimulus(sel(3), 7'h0F, 5);
      checkOutput("post_reset_valid", 32'(out_valid), 32'h1);
      checkOutput("post_reset_bcd", 32'(bcd), 32'h7654);
      applyStimulus(sel(3), 7'h0F, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of multiplexed digits, range 1..8.
REQ-002 SHALL have parameter STABLE_CYCLES, default 4: consecutive identical cycles needed to accept a sample, range 2..255.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port seg, input, 7 bits: active-low segments, bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g.
REQ-006 SHALL have port an, input, DIGITS bits: active-low digit select; an[i]=0 selects digit i.
REQ-007 SHALL have port bcd, output, 4*DIGITS bits: decoded frame; digit i is in bcd[4i+3:4i].
REQ-008 SHALL have port blank_mask, output, DIGITS bits: bit i=1 means digit i was blank.
REQ-009 SHALL have port err_mask, output, DIGITS bits: bit i=1 means digit i held an illegal pattern.
REQ-010 SHALL have port out_valid, output, 1 bit: frame available.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts the frame.
REQ-012 SHALL have port overrun, output, 1 bit: one-cycle pulse when a completed frame is dropped.

Function
REQ-013 SHALL register seg and an every cycle, giving prev_seg and prev_an.
REQ-014 SHALL treat an as qualified only when exactly one bit is 0; an all-1s or multi-zero an is unqualified.
REQ-015 SHALL keep stab_cnt: it increments, saturating at STABLE_CYCLES, while an is qualified and (seg,an) equals (prev_seg,prev_an). Otherwise stab_cnt loads 1 if an is qualified, else 0.
REQ-016 SHALL accept a sample on the cycle stab_cnt transitions to STABLE_CYCLES, once per stable run; cycles after that in the same run are not re-accepted.
REQ-017 SHALL decode an accepted seg to a nibble:
- 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4
- 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0000100=9
- 1111111=4'hF with the blank bit set
- any other pattern=4'hE with the err bit set
REQ-018 SHALL write the decoded nibble, blank bit and err bit into slot i of a staging buffer and set captured[i] on acceptance; a re-capture of the same digit overwrites the slot.
REQ-019 SHALL detect frame complete on the cycle captured becomes all-ones, then clear captured on the next edge.
REQ-020 SHALL on frame complete, when out_valid=0 or out_ready=1, load bcd, blank_mask and err_mask from staging and set out_valid=1 on the following cycle (latency 1 cycle from the final acceptance).
REQ-021 SHALL on frame complete with out_valid=1 and out_ready=0 keep the outputs unchanged, drop the frame and pulse overrun for 1 cycle.
REQ-022 SHALL clear out_valid on the cycle after out_valid=1 and out_ready=1, unless a new frame loads in that same cycle, in which case out_valid stays 1.
REQ-023 SHALL hold bcd, blank_mask and err_mask stable while out_valid=1 and out_ready=0.
REQ-024 SHALL implement a state machine:
- SCAN: collecting digits; goes to LOAD on frame complete.
- LOAD: one cycle that loads or drops the frame; always returns to SCAN.
- Acceptance continues during LOAD.

Reset
REQ-025 SHALL, while rst=1 at a clock edge, set these to 0: bcd, blank_mask, err_mask, out_valid, overrun, captured, stab_cnt, prev_seg and prev_an; staging is cleared and the state is SCAN.
REQ-026 SHALL discard a partially captured frame and any pending output on reset mid-operation; the first frame after reset requires all DIGITS to be recaptured.

Verification
REQ-027 SHALL pass the nominal-frame scenario: STABLE_CYCLES=4, an cycled 1110,1101,1011,0111 at 8 cycles each with patterns for 1,2,3,4 -> out_valid rises 1 cycle after the 4th acceptance, bcd=16'h4321, masks=0.
REQ-028 SHALL pass the short-dwell scenario: digit 2 held for only 3 cycles -> not accepted, no frame; a later 4-cycle dwell completes the frame.
REQ-029 SHALL pass the blank/illegal scenario: digit 0=1111111, digit 1=1111110 -> nibble0=F with blank_mask[0]=1; nibble1=E with err_mask[1]=1.
REQ-030 SHALL pass the backpressure scenario: out_ready=0 while a second frame completes -> overrun pulses 1 cycle and bcd is unchanged; out_ready=1 -> out_valid clears next cycle.
REQ-031 SHALL pass the ghosting/reset scenario: an=1100 for 10 cycles -> no acceptance; rst asserted after 3 digits are captured -> all outputs 0 and the next frame needs all 4 digits.
